// File: rtl/pipeline_parallel_fir_lx_if.sv
// pipeline_parallel_fir_lx_if: sample-block handshake between framer, filter and output formatter
interface pipeline_parallel_fir_lx_if #(
  parameter int L          = 3,
  parameter int DATA_WIDTH = 16
);
  logic                    in_valid;
  logic [L*DATA_WIDTH-1:0] x_in;
  logic                    out_valid;
  logic [L*DATA_WIDTH-1:0] y_out;
  modport master (output in_valid, x_in, input out_valid, y_out);
  modport slave  (input in_valid, x_in, output out_valid, y_out);
endinterface

// File: rtl/pipeline_parallel_fir_lx.sv
// pipeline_parallel_fir_lx: L-parallel FIR with valid handshake, writable coefficients, rounding and sticky saturation
module pipeline_parallel_fir_lx #(
  parameter int TAPS       = 100,
  parameter int L          = 3,
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int FRAC_BITS  = 15,
  parameter int ROUND_MODE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  pipeline_parallel_fir_lx_if.slave    bus,
  input  logic                         coef_wr_en,
  input  logic [$clog2(TAPS)-1:0]      coef_wr_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_wr_data,
  input  logic                         sat_clr,
  output logic [L-1:0]                 sat_flag
);
  localparam int W  = TAPS + L - 1;
  localparam int PW = DATA_WIDTH + COEF_WIDTH;
  localparam int AW = $clog2(TAPS);
  localparam logic signed [ACC_WIDTH-1:0] RND  = ROUND_MODE != 0 ? ACC_WIDTH'(1) << (FRAC_BITS - 1) : '0;
  localparam logic signed [ACC_WIDTH-1:0] MAXV = (ACC_WIDTH'(1) << (DATA_WIDTH - 1)) - ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] MINV = ~MAXV;

  // hist index 0 is the newest sample; lane j of a block sits at index L-1-j
  logic signed [DATA_WIDTH-1:0] hist_q [W], hist_d [W];
  logic signed [COEF_WIDTH-1:0] coef_q [TAPS], coef_d [TAPS];
  logic signed [PW-1:0]         prod_q [L][TAPS], prod_d [L][TAPS];
  logic signed [ACC_WIDTH-1:0]  sum_q [L], sum_d [L];
  logic [DATA_WIDTH:0]          sc [L];
  logic [L*DATA_WIDTH-1:0]      y_q, y_d;
  logic [L-1:0]                 sat_q, sat_d;
  logic                         v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, vo_q, vo_d;

  function automatic logic [DATA_WIDTH:0] scale(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH-1:0] r;
    r = (a + RND) >>> FRAC_BITS;
    return r > MAXV ? {1'b1, MAXV[DATA_WIDTH-1:0]} :
           r < MINV ? {1'b1, MINV[DATA_WIDTH-1:0]} : {1'b0, r[DATA_WIDTH-1:0]};
  endfunction

  always_comb begin
    hist_d = hist_q;
    coef_d = coef_q;
    prod_d = prod_q;
    sum_d  = sum_q;
    y_d    = y_q;
    sat_d  = sat_clr ? '0 : sat_q;
    v1_d   = bus.in_valid && !flush;
    v2_d   = v1_q && !flush;
    v3_d   = v2_q && !flush;
    vo_d   = v3_q && !flush;
    if (flush) hist_d = '{default: '0};
    else if (bus.in_valid) begin
      for (int i = 0; i < L; i++) hist_d[i] = bus.x_in[(L-1-i)*DATA_WIDTH +: DATA_WIDTH];
      for (int i = L; i < W; i++) hist_d[i] = hist_q[i-L];
    end
    if (coef_wr_en && {1'b0, coef_wr_addr} < (AW+1)'(TAPS)) coef_d[coef_wr_addr] = coef_wr_data;
    if (v1_q)
      for (int j = 0; j < L; j++)
        for (int t = 0; t < TAPS; t++) prod_d[j][t] = PW'(hist_q[L-1-j+t]) * PW'(coef_q[t]);
    if (v2_q)
      for (int j = 0; j < L; j++) begin
        sum_d[j] = '0;
        for (int t = 0; t < TAPS; t++) sum_d[j] = sum_d[j] + ACC_WIDTH'(prod_q[j][t]);
      end
    for (int j = 0; j < L; j++) begin
      sc[j] = scale(sum_q[j]);
      if (v3_q && !flush) begin
        y_d[j*DATA_WIDTH +: DATA_WIDTH] = sc[j][DATA_WIDTH-1:0];
        sat_d[j] = sat_d[j] | sc[j][DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hist_q <= '{default: '0};
      coef_q <= '{default: '0};
      prod_q <= '{default: '{default: '0}};
      sum_q  <= '{default: '0};
      y_q    <= '0;
      sat_q  <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      vo_q   <= 1'b0;
    end else begin
      hist_q <= hist_d;
      coef_q <= coef_d;
      prod_q <= prod_d;
      sum_q  <= sum_d;
      y_q    <= y_d;
      sat_q  <= sat_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      vo_q   <= vo_d;
    end

  assign bus.out_valid = vo_q;
  assign bus.y_out     = y_q;
  assign sat_flag      = sat_q;
endmodule

// File: tb/tb_pipeline_parallel_fir_lx.sv
// tb_pipeline_parallel_fir_lx: scoreboard bench running round-half-up and truncating instances in lockstep
module tb_pipeline_parallel_fir_lx;
  localparam int TAPS = 100, L = 3, DW = 16, W = TAPS + L - 1;

  typedef struct {logic [L*DW-1:0] y; int c;} exp_t;

  logic clk = 0, rst = 0, flush = 0, coef_wr_en = 0, sat_clr = 0;
  logic [6:0] coef_wr_addr = '0;
  logic [15:0] coef_wr_data = '0;
  logic [L-1:0] sat1, sat0;
  int n_chk = 0, n_fail = 0, cyc = 0, ov1 = 0, base;
  longint cf [TAPS];
  longint xh [W];
  exp_t q1 [$], q0 [$];
  exp_t e1, e0;

  pipeline_parallel_fir_lx_if #(.L(L), .DATA_WIDTH(DW)) bus1 (), bus0 ();

  pipeline_parallel_fir_lx #(.ROUND_MODE(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus1), .coef_wr_en(coef_wr_en),
    .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data), .sat_clr(sat_clr), .sat_flag(sat1));

  pipeline_parallel_fir_lx #(.ROUND_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus0), .coef_wr_en(coef_wr_en),
    .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data), .sat_clr(sat_clr), .sat_flag(sat0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] scale(input longint a, input bit rm);
    longint s;
    s = (a + (rm ? 64'sd16384 : 64'sd0)) >>> 15;
    return s > 32767 ? 16'h7fff : s < -32768 ? 16'h8000 : s[15:0];
  endfunction

  task automatic push_block(input logic [L*DW-1:0] x);
    exp_t a, b;
    longint acc;
    for (int i = W - 1; i >= L; i--) xh[i] = xh[i-L];
    for (int j = 0; j < L; j++) xh[L-1-j] = longint'($signed(x[j*DW +: DW]));
    for (int j = 0; j < L; j++) begin
      acc = 0;
      for (int t = 0; t < TAPS; t++) acc += cf[t] * xh[L-1-j+t];
      a.y[j*DW +: DW] = scale(acc, 1'b1);
      b.y[j*DW +: DW] = scale(acc, 1'b0);
    end
    a.c = cyc + 4;
    b.c = cyc + 4;
    q1.push_back(a);
    q0.push_back(b);
  endtask

  task automatic drv(input bit v = 0, input logic [L*DW-1:0] x = '0, input bit we = 0,
                     input int wa = 0, input int wd = 0, input bit fl = 0, input bit sc = 0);
    bus1.in_valid = v;
    bus0.in_valid = v;
    bus1.x_in = x;
    bus0.x_in = x;
    flush = fl;
    sat_clr = sc;
    coef_wr_en = we;
    coef_wr_addr = 7'(wa);
    coef_wr_data = 16'(wd);
    if (we && wa < TAPS) cf[wa] = longint'($signed(16'(wd)));
    if (fl) xh = '{default: 0};
    else if (v) push_block(x);
    @(posedge clk);
    #1;
    if (fl) begin
      q1.delete();
      q0.delete();
    end
  endtask

  task automatic do_reset();
    rst = 0;
    cf = '{default: 0};
    xh = '{default: 0};
    q1.delete();
    q0.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
  endtask

  always @(negedge clk)
    if (rst) begin
      if (bus1.out_valid) begin
        ov1++;
        check("q1_nonempty", 64'(q1.size() > 0), 1);
        if (q1.size() > 0) begin
          e1 = q1.pop_front();
          check("y_rnd", bus1.y_out, e1.y);
          check("lat_rnd", cyc, e1.c);
        end
      end
      if (bus0.out_valid) begin
        check("q0_nonempty", 64'(q0.size() > 0), 1);
        if (q0.size() > 0) begin
          e0 = q0.pop_front();
          check("y_trunc", bus0.y_out, e0.y);
          check("lat_trunc", cyc, e0.c);
        end
      end
    end

  initial begin
    #500000;
    $display("FAIL watchdog n_chk=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    bus1.in_valid = 0;
    bus0.in_valid = 0;
    bus1.x_in = '0;
    bus0.x_in = '0;
    do_reset();
    check("rst_ov", bus1.out_valid, 0);
    check("rst_y", bus1.y_out, 0);
    check("rst_sat", sat1, 0);
    // impulse through all taps
    for (int t = 0; t < TAPS; t++) drv(.we(1), .wa(t), .wd('h2000));
    drv(.v(1), .x(48'h4000));
    repeat (39) drv(.v(1));
    repeat (6) drv();
    // same stream with random gaps
    drv(.fl(1));
    base = ov1;
    for (int b = 0; b < 40; b++) begin
      repeat ($urandom_range(0, 2)) drv();
      drv(.v(1), .x(b == 0 ? 48'h4000 : 48'h0));
    end
    repeat (6) drv();
    check("gap_count", ov1 - base, 40);
    // c[0] rewritten on the edge that captures the first block's products
    drv(.fl(1));
    drv(.v(1), .x(48'h4000));
    drv(.v(1), .x(48'h4000), .we(1), .wa(0), .wd('h4000));
    repeat (6) drv();
    check("coef_new", bus1.y_out[15:0], 16'h3000);
    // flush with two blocks in flight
    drv(.v(1), .x(48'h7fff_7fff_7fff));
    drv(.v(1), .x(48'h7fff_7fff_7fff));
    drv(.v(1), .x(48'h4000), .fl(1));
    check("flush_ov", bus1.out_valid, 0);
    drv(.v(1), .x(48'h4000));
    repeat (3) drv(.v(1));
    repeat (6) drv();
    // rounding modes
    do_reset();
    drv(.we(1), .wa(0), .wd(1));
    drv(.v(1), .x(48'h4000));
    repeat (6) drv();
    check("rnd_half_up", bus1.y_out[15:0], 16'h0001);
    check("rnd_trunc", bus0.y_out[15:0], 16'h0000);
    // saturation
    do_reset();
    for (int t = 0; t < TAPS; t++) drv(.we(1), .wa(t), .wd('h7fff));
    repeat (40) drv(.v(1), .x(48'h7fff_7fff_7fff));
    repeat (6) drv();
    check("sat_pos_y", bus1.y_out, 48'h7fff_7fff_7fff);
    check("sat_pos_flag", sat1, 3'b111);
    for (int b = 0; b < 40; b++) begin
      drv(.v(1), .x(48'h8000_8000_8000), .sc(b == 38));
      if (b == 38) check("sat_set_wins", sat1, 3'b111);
    end
    repeat (6) drv();
    check("sat_neg_y", bus1.y_out, 48'h8000_8000_8000);
    check("sat_neg_flag", sat0, 3'b111);
    drv(.sc(1));
    check("sat_clr", sat1, 3'b000);
    // asynchronous reset mid-stream
    repeat (10) drv(.v(1), .x(48'h7fff_7fff_7fff));
    check("pre_rst_sat", sat1, 3'b111);
    check("pre_rst_ov", bus1.out_valid, 1);
    #2;
    rst = 0;
    bus1.in_valid = 0;
    bus0.in_valid = 0;
    #1;
    check("arst_ov", bus1.out_valid, 0);
    check("arst_y", bus1.y_out, 0);
    check("arst_sat", sat1, 0);
    cf = '{default: 0};
    xh = '{default: 0};
    q1.delete();
    q0.delete();
    @(posedge clk);
    #1;
    rst = 1;
    drv(.v(1), .x(48'h4000));
    repeat (39) drv(.v(1));
    repeat (6) drv();
    check("post_rst_y", bus1.y_out, 0);
    check("drain_rnd", q1.size(), 0);
    check("drain_trunc", q0.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
